emb_layer_seq: RTL and testbench

Parametrised successor to the fully parallel embedding layer. Maps N character codes to N embedding vectors (EMB_DIM words of N_LEN bits each) using P table-lookup lanes that are time-multiplexed over G = ceil(N/P) pipelined passes. Trades area for latency. Adds a busy/valid handshake, out-of-range code detection and a zero-vector fallback. Sits between the character input buffer and the first compute layer; output packing is identical to the parallel layer.

---
 rtl/emb_layer_seq_pkg.sv | 22 ++
 rtl/emb_layer_seq_rom.sv | 37 +++
 rtl/emb_layer_seq.sv | 213 +++++++++++++++++++++
 tb/tb_emb_layer_seq.sv | 159 +++++++++++++++
 4 files changed

// File: rtl/emb_layer_seq_pkg.sv
// Shared defaults, state encoding and helpers for the sequential embedding layer.
package emb_layer_seq_pkg;

  localparam int unsigned N_DEF        = 10;
  localparam int unsigned CHAR_LEN_DEF = 8;
  localparam int unsigned EMB_DIM_DEF  = 24;
  localparam int unsigned N_LEN_DEF    = 16;
  localparam int unsigned VOCAB_DEF    = 200;
  localparam int unsigned EMB_LANES    = 4;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  function automatic int unsigned ceil_div(input int unsigned a, input int unsigned b);
    return (a + b - 1) / b;
  endfunction

endpackage

// File: rtl/emb_layer_seq_rom.sv
// Synchronous single-port ROM, 1-cycle read latency, built-in ramp image
// (word k of entry a = a*WORDS + k).
module emb_rom #(
  parameter int unsigned DEPTH     = 256,
  parameter int unsigned WIDTH     = 16,
  parameter int unsigned WORD_W    = 16,
  parameter string       INIT_FILE = "",
  localparam int unsigned AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic [AW-1:0]    addr,
  output logic [WIDTH-1:0] dout
);

  localparam int unsigned WORDS = WIDTH / WORD_W;

  typedef logic [WIDTH-1:0] image_t [DEPTH];

  function automatic image_t load_image();
    image_t img;
    for (int a = 0; a < int'(DEPTH); a++) begin
      img[a] = '0;
      for (int k = 0; k < int'(WORDS); k++) begin
        img[a][k*WORD_W +: WORD_W] = WORD_W'(a * int'(WORDS) + k);
      end
    end
    return img;
  endfunction

  logic [WIDTH-1:0] mem [DEPTH] = load_image();

  // No reset on the read register so the array can map onto a memory macro.
  always_ff @(posedge clk) begin
    dout <= (32'(addr) < DEPTH) ? mem[addr] : '0;
  end

endmodule

// File: rtl/emb_layer_seq.sv
// Time-multiplexed embedding layer: P lookup lanes over ceil(N/P) pipelined passes.
// Optional feature macro: EMB_POS_EN (adds a saturating positional-embedding table).
module emb_layer_seq
  import emb_layer_seq_pkg::*;
#(
  parameter int unsigned N         = N_DEF,
  parameter int unsigned CHAR_LEN  = CHAR_LEN_DEF,
  parameter int unsigned EMB_DIM   = EMB_DIM_DEF,
  parameter int unsigned N_LEN     = N_LEN_DEF,
  parameter int unsigned VOCAB     = VOCAB_DEF,
  parameter int unsigned P         = EMB_LANES,
  parameter string       INIT_FILE = "emb_table.mem"
`ifdef EMB_POS_EN
  ,
  parameter string       POS_FILE  = "emb_pos.mem"
`endif
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        run,
  input  logic [N*CHAR_LEN-1:0]       d,
  output logic                        busy,
  output logic                        valid,
  output logic                        err,
  output logic [N*EMB_DIM*N_LEN-1:0]  q
);

  localparam int unsigned G     = ceil_div(N, P);
  localparam int unsigned GW    = (G > 1) ? $clog2(G) : 1;
  localparam int unsigned SW    = (N > 1) ? $clog2(N) : 1;
  localparam int unsigned AW    = (VOCAB > 1) ? $clog2(VOCAB) : 1;
  localparam int unsigned ROW_W = EMB_DIM * N_LEN;

  state_e              state, state_nxt;
  logic [GW-1:0]       g;
  logic [CHAR_LEN-1:0] codes [N];
  logic                accept_c, issue_c, drain_c, last_c;

  assign last_c = (g == GW'(G - 1));

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE, S_DONE: if (run) state_nxt = S_ISSUE;
      S_ISSUE:        if (last_c) state_nxt = S_DRAIN;
      S_DRAIN:        state_nxt = S_DONE;
      default:        state_nxt = S_IDLE;
    endcase
  end

  // Control strobes
  always_comb begin
    accept_c = 1'b0;
    issue_c  = 1'b0;
    drain_c  = 1'b0;
    case (state)
      S_IDLE, S_DONE: accept_c = run;
      S_ISSUE:        issue_c  = 1'b1;
      S_DRAIN:        drain_c  = 1'b1;
      default:        ;
    endcase
  end

  // Run latch, group counter and handshake flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      g     <= '0;
      busy  <= 1'b0;
      valid <= 1'b0;
      for (int i = 0; i < int'(N); i++) codes[i] <= '0;
    end else begin
      if (accept_c) begin
        g     <= '0;
        busy  <= 1'b1;
        valid <= 1'b0;
        for (int i = 0; i < int'(N); i++) codes[i] <= d[i*CHAR_LEN +: CHAR_LEN];
      end else if (issue_c && !last_c) begin
        g <= g + GW'(1);
      end
      if (drain_c) begin
        busy  <= 1'b0;
        valid <= 1'b1;
      end
    end
  end

  // Issue stage: per-lane slot, enable, range check and ROM address
  logic [P-1:0]  lane_en_c, oor_c;
  logic [SW-1:0] slot_c [P];
  logic [AW-1:0] addr_c [P];

  always_comb begin
    lane_en_c = '0;
    oor_c     = '0;
    for (int unsigned j = 0; j < P; j++) begin
      lane_en_c[j] = issue_c && ((32'(g) * P + j) < N);
      slot_c[j]    = lane_en_c[j] ? SW'(32'(g) * P + j) : '0;
      oor_c[j]     = lane_en_c[j] && (32'(codes[slot_c[j]]) >= VOCAB);
      addr_c[j]    = (lane_en_c[j] && !oor_c[j]) ? AW'(codes[slot_c[j]]) : '0;
    end
  end

  // Write-stage pipeline registers, aligned with the ROM read latency
  logic          wr_en_q;
  logic [P-1:0]  lane_en_q, oor_q;
  logic [SW-1:0] slot_q [P];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_en_q   <= 1'b0;
      lane_en_q <= '0;
      oor_q     <= '0;
      for (int j = 0; j < int'(P); j++) slot_q[j] <= '0;
    end else begin
      wr_en_q   <= issue_c;
      lane_en_q <= lane_en_c;
      oor_q     <= oor_c;
      for (int j = 0; j < int'(P); j++) slot_q[j] <= slot_c[j];
    end
  end

  logic [ROW_W-1:0] tok_row [P];
`ifdef EMB_POS_EN
  logic [ROW_W-1:0] pos_row [P];
`endif

  for (genvar j = 0; j < int'(P); j++) begin : g_lane
    emb_rom #(
      .DEPTH     (VOCAB),
      .WIDTH     (ROW_W),
      .WORD_W    (N_LEN),
      .INIT_FILE (INIT_FILE)
    ) u_tok (
      .clk  (clk),
      .addr (addr_c[j]),
      .dout (tok_row[j])
    );
`ifdef EMB_POS_EN
    emb_rom #(
      .DEPTH     (N),
      .WIDTH     (ROW_W),
      .WORD_W    (N_LEN),
      .INIT_FILE (POS_FILE)
    ) u_pos (
      .clk  (clk),
      .addr (slot_c[j]),
      .dout (pos_row[j])
    );
`endif
  end

`ifdef EMB_POS_EN
  function automatic logic [N_LEN-1:0] sat_add(input logic [N_LEN-1:0] a,
                                               input logic [N_LEN-1:0] b);
    logic [N_LEN:0] s;
    s = {a[N_LEN-1], a} + {b[N_LEN-1], b};
    if (s[N_LEN] != s[N_LEN-1])
      return s[N_LEN] ? {1'b1, {(N_LEN-1){1'b0}}} : {1'b0, {(N_LEN-1){1'b1}}};
    return s[N_LEN-1:0];
  endfunction

  function automatic logic [ROW_W-1:0] sat_row(input logic [ROW_W-1:0] a,
                                               input logic [ROW_W-1:0] b);
    logic [ROW_W-1:0] r;
    for (int k = 0; k < int'(EMB_DIM); k++)
      r[k*N_LEN +: N_LEN] = sat_add(a[k*N_LEN +: N_LEN], b[k*N_LEN +: N_LEN]);
    return r;
  endfunction
`endif

  // Slot data for the write stage; out-of-range codes bypass the token table
  logic [ROW_W-1:0] row_c [P];

  always_comb begin
    for (int j = 0; j < int'(P); j++) begin
`ifdef EMB_POS_EN
      row_c[j] = oor_q[j] ? pos_row[j] : sat_row(tok_row[j], pos_row[j]);
`else
      row_c[j] = oor_q[j] ? '0 : tok_row[j];
`endif
    end
  end

  // Result slots and sticky error
  logic [ROW_W-1:0] q_arr [N];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err <= 1'b0;
      for (int i = 0; i < int'(N); i++) q_arr[i] <= '0;
    end else begin
      if (accept_c) err <= 1'b0;
      for (int j = 0; j < int'(P); j++) begin
        if (wr_en_q && lane_en_q[j]) begin
          q_arr[slot_q[j]] <= row_c[j];
          if (oor_q[j]) err <= 1'b1;
        end
      end
    end
  end

  for (genvar i = 0; i < int'(N); i++) begin : g_pack
    assign q[i*ROW_W +: ROW_W] = q_arr[i];
  end

endmodule

// File: tb/tb_emb_layer_seq.sv
// Scoreboard bench: three lane counts (P=4, 1, 10) run the same stimulus in parallel.
module tb_emb_layer_seq;

  localparam int unsigned N     = 10;
  localparam int unsigned CL    = 8;
  localparam int unsigned ED    = 24;
  localparam int unsigned NL    = 16;
  localparam int unsigned VOC   = 200;
  localparam int unsigned ROW_W = ED * NL;
  localparam int unsigned QW    = N * ROW_W;
  localparam int          NI    = 3;

  typedef struct packed {
    logic [QW-1:0] q;
    logic          err;
  } exp_t;

  logic          clk, rst_n, run;
  logic [N*CL-1:0] d;
  logic          busy_o  [NI];
  logic          valid_o [NI];
  logic          err_o   [NI];
  logic [QW-1:0] q_o     [NI];

  int   lat_exp [NI] = '{4, 11, 2};
  int   lat     [NI];
  int   codes   [N];
  exp_t sb      [NI][$];
  int   total = 0;
  int   bad   = 0;

  emb_layer_seq #(.P(4),  .INIT_FILE("")) u_p4  (.clk(clk), .rst_n(rst_n), .run(run), .d(d),
    .busy(busy_o[0]), .valid(valid_o[0]), .err(err_o[0]), .q(q_o[0]));
  emb_layer_seq #(.P(1),  .INIT_FILE("")) u_p1  (.clk(clk), .rst_n(rst_n), .run(run), .d(d),
    .busy(busy_o[1]), .valid(valid_o[1]), .err(err_o[1]), .q(q_o[1]));
  emb_layer_seq #(.P(10), .INIT_FILE("")) u_p10 (.clk(clk), .rst_n(rst_n), .run(run), .d(d),
    .busy(busy_o[2]), .valid(valid_o[2]), .err(err_o[2]), .q(q_o[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [ROW_W-1:0] got,
                       input logic [ROW_W-1:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic exp_t model();
    exp_t e;
    e = '0;
    for (int i = 0; i < int'(N); i++) begin
      if (codes[i] >= int'(VOC)) e.err = 1'b1;
      for (int k = 0; k < int'(ED); k++)
        e.q[(i*ED + k)*NL +: NL] = (codes[i] < int'(VOC)) ? NL'(codes[i] * int'(ED) + k) : '0;
    end
    return e;
  endfunction

  task automatic compare_result(input int i, input string tag);
    exp_t e;
    if (sb[i].size() == 0) begin
      check($sformatf("%s_sb_empty[%0d]", tag, i), ROW_W'(1), ROW_W'(0));
      return;
    end
    e = sb[i].pop_front();
    for (int s = 0; s < int'(N); s++)
      check($sformatf("%s_slot%0d[%0d]", tag, s, i), q_o[i][s*ROW_W +: ROW_W],
            e.q[s*ROW_W +: ROW_W]);
    check($sformatf("%s_err[%0d]", tag, i), ROW_W'(err_o[i]), ROW_W'(e.err));
    check($sformatf("%s_busy_at_valid[%0d]", tag, i), ROW_W'(busy_o[i]), ROW_W'(0));
  endtask

  // Called at a negedge; drives one run and checks all three instances to completion
  task automatic run_and_check(input string tag, input bit extra_run);
    exp_t e;
    e = model();
    for (int i = 0; i < NI; i++) sb[i].push_back(e);
    for (int i = 0; i < int'(N); i++) d[i*CL +: CL] = CL'(codes[i]);
    run = 1'b1;
    @(negedge clk);
    for (int i = 0; i < NI; i++) begin
      check($sformatf("%s_valid_after_accept[%0d]", tag, i), ROW_W'(valid_o[i]), ROW_W'(0));
      lat[i] = 0;
    end
    for (int c = 1; c <= 20; c++) begin
      run = (extra_run && c == 2);
      @(negedge clk);
      for (int i = 0; i < NI; i++) begin
        if (c == 1) check($sformatf("%s_busy_e1[%0d]", tag, i), ROW_W'(busy_o[i]), ROW_W'(1));
        if (lat[i] == 0 && valid_o[i]) begin
          lat[i] = c;
          compare_result(i, tag);
        end
      end
    end
    run = 1'b0;
    for (int i = 0; i < NI; i++) begin
      check($sformatf("%s_latency[%0d]", tag, i), ROW_W'(lat[i]), ROW_W'(lat_exp[i]));
      check($sformatf("%s_valid_hold[%0d]", tag, i), ROW_W'(valid_o[i]), ROW_W'(1));
      check($sformatf("%s_busy_end[%0d]", tag, i), ROW_W'(busy_o[i]), ROW_W'(0));
    end
  endtask

  task automatic check_cleared(input string tag);
    for (int i = 0; i < NI; i++) begin
      check($sformatf("%s_q[%0d]", tag, i), ROW_W'(|q_o[i]), ROW_W'(0));
      check($sformatf("%s_valid[%0d]", tag, i), ROW_W'(valid_o[i]), ROW_W'(0));
      check($sformatf("%s_busy[%0d]", tag, i), ROW_W'(busy_o[i]), ROW_W'(0));
      check($sformatf("%s_err[%0d]", tag, i), ROW_W'(err_o[i]), ROW_W'(0));
    end
  endtask

  initial begin
    rst_n = 1'b0;
    run   = 1'b0;
    d     = '0;
    repeat (2) @(negedge clk);
    check_cleared("reset");
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < int'(N); i++) codes[i] = i;
    run_and_check("ramp", 1'b0);

    codes = '{7, 42, 199, 200, 0, 13, 150, 88, 3, 255};
    run_and_check("oor", 1'b0);

    for (int i = 0; i < int'(N); i++) codes[i] = int'($urandom_range(0, VOC - 1));
    run_and_check("rand", 1'b0);

    codes = '{199, 1, 2, 198, 100, 50, 25, 12, 6, 0};
    run_and_check("busy_run", 1'b1);

    // Abort mid-issue with an asynchronous reset
    for (int i = 0; i < int'(N); i++) begin
      codes[i] = 9 - i;
      d[i*CL +: CL] = CL'(codes[i]);
    end
    run = 1'b1;
    @(negedge clk);
    run = 1'b0;
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b0;
    #1 check_cleared("abort");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_cleared("abort_idle");

    run_and_check("after_abort", 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
